mem_port_master: RTL and testbench

Single-port initiator that drives one chip-select/write-enable/output-enable SRAM-style port with a shared bidirectional data bus. Sits between an internal valid/ready request interface and one port of the team's dual-port memory. It turns each accepted request into one correctly sequenced bus write or bus read and returns read data on a one-cycle response strobe.

---
 rtl/mem_port_master.sv | 120 ++++++++++++
 tb/tb_mem_port_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// Single-port initiator for a CS/WE/OE SRAM-style port with a shared tri-state data bus.
// Optional MEM_PORT_MASTER_TURNAROUND_EN inserts one idle TURN cycle after every read.
module mem_port_master #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    inout  logic [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
`ifdef MEM_PORT_MASTER_TURNAROUND_EN
        ST_READ,
        ST_TURN
`else
        ST_READ
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  ready_q, cs_q, we_q, oe_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    rdata_d     = mem_data;
                    rsp_valid_d = 1'b1;
`ifdef MEM_PORT_MASTER_TURNAROUND_EN
                    state_d     = ST_TURN;
`else
                    state_d     = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef MEM_PORT_MASTER_TURNAROUND_EN
            ST_TURN: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus controls are registered from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= (state_d == ST_IDLE);
            cs_q        <= (state_d == ST_WRITE) || (state_d == ST_READ);
            we_q        <= (state_d == ST_WRITE);
            oe_q        <= (state_d == ST_READ);
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;
    assign mem_data  = we_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master: W=0 instance with table vectors and corner sequences,
// plus a WAIT_STATES=2 instance for the extended read.
module tb_mem_port_master;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // W=0 instance
    logic        req_valid, req_we, req_ready, rsp_valid;
    logic [15:0] req_addr, mem_addr;
    logic [3:0]  req_wdata, rsp_rdata;
    logic        mem_cs, mem_we, mem_oe;
    tri1  [3:0]  mem_data;
    logic [3:0]  mem0 [0:65535];

    mem_port_master #(.DATA_WIDTH(4), .ADDR_WIDTH(16), .WAIT_STATES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_data(mem_data)
    );
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? mem0[mem_addr] : 'z;
    always @(posedge clk) if (mem_cs && mem_we) mem0[mem_addr] <= mem_data;

    // W=2 instance
    logic        r2_valid, r2_we, r2_ready, r2_rsp_valid;
    logic [15:0] r2_addr, m2_addr;
    logic [3:0]  r2_wdata, r2_rdata;
    logic        m2_cs, m2_we, m2_oe;
    tri1  [3:0]  m2_data;
    logic [3:0]  mem2 [0:65535];

    mem_port_master #(.DATA_WIDTH(4), .ADDR_WIDTH(16), .WAIT_STATES(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r2_valid), .req_ready(r2_ready), .req_we(r2_we),
        .req_addr(r2_addr), .req_wdata(r2_wdata),
        .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata),
        .mem_addr(m2_addr), .mem_cs(m2_cs), .mem_we(m2_we), .mem_oe(m2_oe),
        .mem_data(m2_data)
    );
    assign m2_data = (m2_cs && m2_oe && !m2_we) ? mem2[m2_addr] : 'z;
    always @(posedge clk) if (m2_cs && m2_we) mem2[m2_addr] <= m2_data;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned viol  = 0;
    logic [3:0]  rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus-protocol monitor on the W=0 port; undriven bus reads as all ones through the pull-up.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) rsp_q.push_back(rsp_rdata);
            if (mem_we && mem_oe) viol++;
            if (mem_oe && $isunknown(mem_data)) viol++;
            if (!mem_cs && mem_data !== 4'hF) viol++;
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  wdata;
        logic [3:0]  exp;
    } vec_t;

    task automatic do_req(input vec_t v);
        int n;
        int lat;
        int cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        while (!req_ready && n < 16) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(n < 16), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("cs_on", 32'(mem_cs), 32'd1);
        chk("addr", 32'(mem_addr), 32'(v.addr));
        chk("ready_busy", 32'(req_ready), 32'd0);
        if (v.we) begin
            chk("we_on", 32'(mem_we), 32'd1);
            chk("oe_off_wr", 32'(mem_oe), 32'd0);
            chk("bus_wdata", 32'(mem_data), 32'(v.wdata));
            @(negedge clk);
            chk("cs_off_wr", 32'(mem_cs), 32'd0);
            chk("ready_back", 32'(req_ready), 32'd1);
            chk("no_rsp_wr", 32'(rsp_valid), 32'd0);
        end else begin
            lat = 0; cnt = 0;
            while (!rsp_valid && lat < 20) begin
                if (mem_cs && mem_oe && !mem_we) cnt++;
                @(negedge clk);
                lat++;
            end
            chk("rd_latency", 32'(lat), 32'd1);
            chk("rd_oe_cycles", 32'(cnt), 32'd1);
            chk("rd_data", 32'(rsp_rdata), 32'(v.exp));
            chk("rd_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            chk("rsp_pulse", 32'(rsp_valid), 32'd0);
            chk("rdata_hold", 32'(rsp_rdata), 32'(v.exp));
        end
    endtask

    initial begin
        vec_t vecs[10];
        vec_t b2b[4];
        int n, lat, cnt, dead;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t b2b[4];
        int n, lat, cnt, dead;

        vecs[0] = '{1'b1, 16'h0003, 4'hA, 4'h0};
        vecs[1] = '{1'b0, 16'h0003, 4'h0, 4'hA};
        vecs[2] = '{1'b1, 16'hFFFF, 4'h5, 4'h0};
        vecs[3] = '{1'b0, 16'hFFFF, 4'h0, 4'h5};
        vecs[4] = '{1'b1, 16'h0000, 4'hF, 4'h0};
        vecs[5] = '{1'b0, 16'h0000, 4'h0, 4'hF};
        vecs[6] = '{1'b0, 16'h0003, 4'h0, 4'hA};
        vecs[7] = '{1'b1, 16'h0003, 4'h0, 4'h0};
        vecs[8] = '{1'b0, 16'h0003, 4'h0, 4'h0};
        vecs[9] = '{1'b0, 16'h0042, 4'h0, 4'h0};
        b2b[0]  = '{1'b1, 16'h0000, 4'h1, 4'h0};
        b2b[1]  = '{1'b1, 16'h0001, 4'h2, 4'h0};
        b2b[2]  = '{1'b0, 16'h0000, 4'h0, 4'h1};
        b2b[3]  = '{1'b0, 16'h0001, 4'h0, 4'h2};

        for (int i = 0; i < 65536; i++) begin mem0[i] = 4'h0; mem2[i] = 4'h0; end
        mem2[5] = 4'h6;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        r2_valid  = 1'b0; r2_we  = 1'b0; r2_addr  = '0; r2_wdata  = '0;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_ctrl", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
        chk("rst_bus_hiz", 32'(mem_data), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 10; i++) do_req(vecs[i]);

        // WAIT_STATES=2 read of addr 5
        @(negedge clk);
        r2_valid = 1'b1; r2_we = 1'b0; r2_addr = 16'h0005;
        n = 0;
        while (!r2_ready && n < 16) begin @(negedge clk); n++; end
        @(negedge clk);
        r2_valid = 1'b0;
        lat = 0; cnt = 0;
        while (!r2_rsp_valid && lat < 20) begin
            if (m2_cs && m2_oe && !m2_we) cnt++;
            @(negedge clk);
            lat++;
        end
        chk("w2_latency", 32'(lat), 32'd3);
        chk("w2_oe_cycles", 32'(cnt), 32'd3);
        chk("w2_rdata", 32'(r2_rdata), 32'h6);
        chk("w2_ctrl_off", 32'({m2_cs, m2_oe}), 32'd0);
        @(negedge clk);
        chk("w2_pulse", 32'(r2_rsp_valid), 32'd0);

        // Back-to-back with req_valid held high throughout
        rsp_q.delete();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = b2b[i].we; req_addr = b2b[i].addr; req_wdata = b2b[i].wdata;
            n = 0;
            @(negedge clk);
            while (!req_ready && n < 16) begin @(negedge clk); n++; end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() < 2 && n < 16) begin @(negedge clk); n++; end
        chk("b2b_count", 32'(rsp_q.size()), 32'd2);
        if (rsp_q.size() >= 2) begin
            chk("b2b_rd0", 32'(rsp_q[0]), 32'h1);
            chk("b2b_rd1", 32'(rsp_q[1]), 32'h2);
        end

        // Read followed by held write: turnaround spacing
        do_req('{1'b1, 16'h0010, 4'hC, 4'h0});
        rsp_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_wdata = 4'h0;
        n = 0;
        while (!req_ready && n < 16) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req_we = 1'b1; req_addr = 16'h0011; req_wdata = 4'h3;
        n = 0; dead = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_ready) begin @(posedge clk); n++; break; end
            if (!mem_cs && !mem_we && !mem_oe) dead++;
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
`ifdef MEM_PORT_MASTER_TURNAROUND_EN
        chk("turn_spacing", 32'(n), 32'd3);
        chk("turn_dead", 32'(dead), 32'd1);
`else
        chk("turn_spacing", 32'(n), 32'd2);
        chk("turn_dead", 32'(dead), 32'd0);
`endif
        chk("turn_wr_we", 32'(mem_we), 32'd1);
        chk("turn_wr_data", 32'(mem_data), 32'h3);
        chk("turn_rd_count", 32'(rsp_q.size()), 32'd1);
        if (rsp_q.size() >= 1) chk("turn_rd_data", 32'(rsp_q[0]), 32'hC);

        // Reset asserted in the middle of a READ at 0x0007
        mem0[7] = 4'h9;
        repeat (2) @(negedge clk);
        rsp_q.delete();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0007;
        n = 0;
        while (!req_ready && n < 16) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_cs_before", 32'(mem_cs), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_cs_drop", 32'(mem_cs), 32'd0);
        chk("abort_oe_drop", 32'(mem_oe), 32'd0);
        chk("abort_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_pulse", 32'(rsp_q.size()), 32'd0);
        chk("abort_rdata", 32'(rsp_rdata), 32'd0);

        // Idle reset after activity leaves mem_addr nonzero
        do_req('{1'b1, 16'h1234, 4'h7, 4'h0});
        chk("rst2_pre_addr", 32'(mem_addr), 32'h1234);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_addr", 32'(mem_addr), 32'd0);
        chk("rst2_ctrl", 32'({mem_cs, mem_we, mem_oe}), 32'd0);
        chk("rst2_bus_hiz", 32'(mem_data), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_ready", 32'(req_ready), 32'd1);
        chk("mem_commit", 32'(mem0[16'h1234]), 32'h7);

        chk("bus_protocol_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
